// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared constants for the 8-way round-robin arbiter slice:
//                requester count, index width and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Arbiter FSM state encodings
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dec3to8.sv
`default_nettype none
// ============================================================================
//  Module      : dec3to8
//  Description : 3-to-8 one-hot decoder with enable; output is all zeros
//                whenever the enable is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec3to8 (
    input  logic [2:0] i_sel,
    input  logic       i_en,
    output logic [7:0] o_dec
);

    // One-hot decode of the select, forced to zero when disabled
    always_comb begin
        o_dec = 8'h00;
        if (i_en) begin
            o_dec = 8'h01 << i_sel;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arb_dec8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_dec8
//  Description : 8-way round-robin arbiter for one shared slave. Holds a grant
//                until the owner releases (done or request drop) or a hold
//                timeout expires, inserts a one-cycle dead gap, then
//                re-arbitrates from a rotating priority pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_dec8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic             r_timeout;

    logic [IDX_W-1:0] w_winner;
    logic             w_any_req;
    logic             w_owner_drop;
    logic             w_hold_max;
    logic             w_release;
    logic [N_REQ-1:0] w_dec;

    // First set request at or after the pointer, wrapping 7 -> 0. Scanning
    // offsets from high to low lets the smallest offset win, which is the
    // same as rotating by ptr, priority-encoding and adding ptr back.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] k;
        pick = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = p + IDX_W'(i);
            if (r[k]) begin
                pick = k;
            end
        end
        return pick;
    endfunction

    // Arbitration and release conditions
    always_comb begin
        w_winner     = rr_pick(req, r_ptr);
        w_any_req    = |req;
        w_owner_drop = ~req[r_gnt_idx];
        w_hold_max   = (r_hold_cnt == c_hold_last);
        w_release    = done | w_owner_drop | w_hold_max;
    end

    // Grant FSM; RELEASE arbitrates on its exit edge so the dead gap
    // between two grants is exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE, RELEASE: begin
                    r_gnt_valid <= 1'b0;
                    if (w_any_req) begin
                        r_state     <= GRANT;
                        r_gnt_idx   <= w_winner;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_ptr       <= w_winner + c_idx_one;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GRANT: begin
                    r_hold_cnt <= r_hold_cnt + c_cnt_one;
                    if (w_release) begin
                        r_state     <= RELEASE;
                        r_gnt_valid <= 1'b0;
                        // Only a pure timeout is flagged; an owner release
                        // in the same cycle takes precedence
                        r_timeout   <= w_hold_max & ~done & ~w_owner_drop;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    dec3to8 u_dec (
        .i_sel (r_gnt_idx),
        .i_en  (r_gnt_valid),
        .o_dec (w_dec)
    );

    // Explicit gating keeps gnt at zero whenever no grant is active
    always_comb begin
        gnt = r_gnt_valid ? w_dec : {N_REQ{1'b0}};
    end

    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_dec8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb_dec8
//  Description : Directed self-checking bench for rr_arb_dec8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_dec8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_pass  = 0;
    int n_check = 0;

    rr_arb_dec8 #(
        .MAX_HOLD (16),
        .CNT_W    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                             input logic e_valid, input logic e_to);
        check({tag, ".gnt"},       {24'd0, gnt},       {24'd0, e_gnt});
        check({tag, ".gnt_idx"},   {29'd0, gnt_idx},   {29'd0, e_idx});
        check({tag, ".gnt_valid"}, {31'd0, gnt_valid}, {31'd0, e_valid});
        check({tag, ".timeout"},   {31'd0, timeout},   {31'd0, e_to});
    endtask

    initial begin
        logic [7:0] e;
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;

        // Reset with all requesting: nothing granted
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

        // All requesting, done one cycle into each grant: 0..7 then 0
        for (int i = 0; i < 8; i++) begin
            e = 8'h01 << i;
            check("rr.gnt", {24'd0, gnt}, {24'd0, e});
            check("rr.idx", {29'd0, gnt_idx}, i);
            done = 1'b1;
            @(negedge clk);
            check("rr.gap", {24'd0, gnt}, 32'd0);
            done = 1'b0;
            @(negedge clk);
        end
        check_out("rr_wrap", 8'h01, 3'd0, 1'b1, 1'b0);

        // Move the grant to master 5 (ptr=1 so 5 beats 0)
        req  = 8'h21;
        done = 1'b1;
        @(negedge clk);
        check_out("to5_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        req  = 8'h20;
        @(negedge clk);
        check_out("own5", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'h24;
        @(negedge clk);
        check("own5_hold", {24'd0, gnt}, 32'h20);
        // Owner 5 drops its request with 2 waiting
        req = 8'h04;
        @(negedge clk);
        check_out("drop5_gap", 8'h00, 3'd5, 1'b0, 1'b0);
        @(negedge clk);
        check_out("own2", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h00;
        @(negedge clk);
        check("drop2_gap", {24'd0, gnt}, 32'd0);
        @(negedge clk);
        // done while idle does nothing
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check_out("idle_done", 8'h00, 3'd2, 1'b0, 1'b0);

        // Build ptr=6 by granting 5, then wrap-around to 0
        req = 8'h20;
        @(negedge clk);
        check("set_ptr6", {24'd0, gnt}, 32'h20);
        req = 8'h03;
        @(negedge clk);
        check("wrap_gap", {24'd0, gnt}, 32'd0);
        @(negedge clk);
        check_out("wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        check_out("ptr1", 8'h02, 3'd1, 1'b1, 1'b0);

        // Single requester 3 held without done: forced release by timeout
        req = 8'h08;
        @(negedge clk);
        check("to3_gap", {24'd0, gnt}, 32'd0);
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            check("hold.gnt", {24'd0, gnt}, 32'h08);
            check("hold.timeout", {31'd0, timeout}, 32'd0);
            @(negedge clk);
        end
        check_out("timeout", 8'h00, 3'd3, 1'b0, 1'b1);
        @(negedge clk);
        check_out("regrant3", 8'h08, 3'd3, 1'b1, 1'b0);

        // Asynchronous reset mid-grant, between clock edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_out("post_rst", 8'h08, 3'd3, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire
